// File: rtl/imem_loader.sv
// Serial boot loader: streams A5 / length / little-endian words into IMEM.
// Optional XOR checksum trailer enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [63:0] BASE_ADR  = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [63:0] imem_adr,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic        take;
  logic        fin_q;
  logic [15:0] len_q;
  logic [15:0] len_full;
  logic [1:0]  byte_cnt_q;
  logic [15:0] word_cnt_q;
  logic [23:0] wbuf_q;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign byte_ready = (state_q != DONE) && (state_q != ERR);
  assign take       = byte_valid && byte_ready;
  assign len_full   = {byte_in, len_q[7:0]};
  assign last_word  = (word_cnt_q == (len_q - 16'd1));
  assign fin_q      = (state_q == DONE) || (state_q == ERR);
  assign cpu_reset  = (state_q != DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take && byte_in == 8'hA5) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (take) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (take) begin
          if ({1'b0, len_full} > MAX_N) state_d = ERR;
          else if (len_full == 16'd0)   state_d = FIN;
          else                          state_d = DATA;
        end
      end
      DATA: begin
        if (take && byte_cnt_q == 2'd3 && last_word) state_d = FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (take) state_d = (byte_in == csum_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (restart) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      imem_we    <= 1'b0;
      imem_adr   <= 64'h0;
      imem_data  <= 32'h0;
      done       <= 1'b0;
      error      <= 1'b0;
      len_q      <= 16'h0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'h0;
      wbuf_q     <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h0;
`endif
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE);
      error   <= (state_d == ERR);
      imem_we <= 1'b0;
      if (fin_q && restart) begin
        len_q      <= 16'h0;
        byte_cnt_q <= 2'd0;
        word_cnt_q <= 16'h0;
        wbuf_q     <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= 8'h0;
`endif
      end else if (take) begin
        unique case (state_q)
          LEN_LO: len_q[7:0]  <= byte_in;
          LEN_HI: len_q[15:8] <= byte_in;
          DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_in;
`endif
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
              2'd0: wbuf_q[7:0]   <= byte_in;
              2'd1: wbuf_q[15:8]  <= byte_in;
              2'd2: wbuf_q[23:16] <= byte_in;
              default: begin
                imem_we    <= 1'b1;
                imem_adr   <= BASE_ADR + {48'h0, word_cnt_q};
                imem_data  <= {byte_in, wbuf_q};
                word_cnt_q <= word_cnt_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (default and
// BASE_ADR=16/MAX_WORDS=4) fed from one byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'h0;
  logic        byte_valid = 1'b0;
  logic        restart = 1'b0;

  logic        rdy0, we0, cr0, done0, err0;
  logic [63:0] adr0;
  logic [31:0] dat0;
  logic        rdy1, we1, cr1, done1, err1;
  logic [63:0] adr1;
  logic [31:0] dat1;

  logic [63:0] qa0[$];
  logic [31:0] qd0[$];
  logic [63:0] qa1[$];
  logic [31:0] qd1[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_loader u0 (
    .clk(clk), .rst(rst), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy0),
    .restart(restart), .imem_we(we0),
    .imem_adr(adr0), .imem_data(dat0),
    .cpu_reset(cr0), .done(done0), .error(err0)
  );

  imem_loader #(.MAX_WORDS(4), .BASE_ADR(64'd16)) u1 (
    .clk(clk), .rst(rst), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy1),
    .restart(restart), .imem_we(we1),
    .imem_adr(adr1), .imem_data(dat1),
    .cpu_reset(cr1), .done(done1), .error(err1)
  );

  always @(negedge clk) begin
    if (we0) begin
      qa0.push_back(adr0);
      qd0.push_back(dat0);
    end
    if (we1) begin
      qa1.push_back(adr1);
      qd1.push_back(dat1);
    end
  end

  task automatic do_reset();
    byte_valid = 1'b0;
    restart = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    qa0.delete(); qd0.delete();
    qa1.delete(); qd1.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in = 8'hFF;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if (rdy0 !== 1'b1) begin
      fails++; $display("FAIL rst_ready got %0b want 1", rdy0);
    end
    tests++;
    if (we0 !== 1'b0) begin
      fails++; $display("FAIL rst_we got %0b want 0", we0);
    end
    tests++;
    if (adr0 !== 64'h0 || dat0 !== 32'h0) begin
      fails++; $display("FAIL rst_adr_data got %h/%h want 0/0", adr0, dat0);
    end
    tests++;
    if (cr0 !== 1'b1) begin
      fails++; $display("FAIL rst_cpu_reset got %0b want 1", cr0);
    end
    tests++;
    if (done0 !== 1'b0 || err0 !== 1'b0) begin
      fails++; $display("FAIL rst_done_err got %0b%0b want 00", done0, err0);
    end
  endtask

  task automatic test_load2();
    do_reset();
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
    send(8'hB3, 0); send(8'h05, 0); send(8'hB5, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
    send(8'h13 ^ 8'h05 ^ 8'hA0 ^ 8'h00 ^ 8'hB3 ^ 8'h05 ^ 8'hB5 ^ 8'h00, 0);
    @(negedge clk);
    tests++;
    if (done0 !== 1'b1) begin
      fails++; $display("FAIL load2_done got %0b want 1", done0);
    end
`else
    send(8'h00, 0);
    @(negedge clk);
    tests++;
    if (we0 !== 1'b1 || done0 !== 1'b1) begin
      fails++; $display("FAIL load2_last_we_done got %0b%0b want 11", we0, done0);
    end
`endif
    settle();
    tests++;
    if (qa0.size() != 2) begin
      fails++; $display("FAIL load2_count got %0d want 2", qa0.size());
    end
    tests++;
    if (qa0.size() < 1 || qa0[0] !== 64'd0 || qd0[0] !== 32'h00A00513) begin
      fails++; $display("FAIL load2_w0 got %h/%h want 0/00a00513", qa0[0], qd0[0]);
    end
    tests++;
    if (qa0.size() < 2 || qa0[1] !== 64'd1 || qd0[1] !== 32'h00B505B3) begin
      fails++; $display("FAIL load2_w1 got %h/%h want 1/00b505b3", qa0[1], qd0[1]);
    end
    tests++;
    if (adr0 !== 64'd1 || dat0 !== 32'h00B505B3) begin
      fails++; $display("FAIL load2_hold got %h/%h want 1/00b505b3", adr0, dat0);
    end
    tests++;
    if (done0 !== 1'b1 || cr0 !== 1'b0 || rdy0 !== 1'b0 || err0 !== 1'b0) begin
      fails++; $display("FAIL load2_status got d%0b c%0b r%0b e%0b want d1 c0 r0 e0",
                        done0, cr0, rdy0, err0);
    end
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0 || cr0 !== 1'b1 || rdy0 !== 1'b1) begin
      fails++; $display("FAIL load2_restart got d%0b c%0b r%0b want d0 c1 r1",
                        done0, cr0, rdy0);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send(8'h00, 0); send(8'hFF, 0);
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++; $display("FAIL zero_discard got d%0b r%0b want d0 r1", done0, rdy0);
    end
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    settle();
    tests++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || cr0 !== 1'b0) begin
      fails++; $display("FAIL zero_done got d%0b e%0b c%0b want d1 e0 c0", done0, err0, cr0);
    end
    tests++;
    if (qa0.size() != 0) begin
      fails++; $display("FAIL zero_no_we got %0d want 0", qa0.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h04, 0);
    settle();
    tests++;
    if (err0 !== 1'b1 || rdy0 !== 1'b0 || cr0 !== 1'b1 || done0 !== 1'b0) begin
      fails++; $display("FAIL ovf_status got e%0b r%0b c%0b d%0b want e1 r0 c1 d0",
                        err0, rdy0, cr0, done0);
    end
    send(8'h11, 0);
    tests++;
    if (qa0.size() != 0) begin
      fails++; $display("FAIL ovf_no_we got %0d want 0", qa0.size());
    end
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    tests++;
    if (err0 !== 1'b0 || rdy0 !== 1'b1 || cr0 !== 1'b1) begin
      fails++; $display("FAIL ovf_restart got e%0b r%0b c%0b want e0 r1 c1", err0, rdy0, cr0);
    end
  endtask

  task automatic test_max_boundary();
    do_reset();
    send(8'hA5, 0); send(8'h05, 0); send(8'h00, 0);
    @(negedge clk);
    tests++;
    if (err1 !== 1'b1) begin
      fails++; $display("FAIL bound_over got %0b want 1", err1);
    end
    tests++;
    if (err0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++; $display("FAIL bound_big_ok got e%0b r%0b want e0 r1", err0, rdy0);
    end
    do_reset();
    send(8'hA5, 0); send(8'h04, 0); send(8'h00, 0);
    @(negedge clk);
    tests++;
    if (err1 !== 1'b0 || rdy1 !== 1'b1 || done1 !== 1'b0) begin
      fails++; $display("FAIL bound_eq got e%0b r%0b d%0b want e0 r1 d0", err1, rdy1, done1);
    end
  endtask

  task automatic test_abort_gaps();
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    do_reset();
    send(8'hA5, 1); send(8'h01, 1); send(8'h00, 1);
    send(8'h11, 1); send(8'h22, 0);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    send(8'h33, 1);
    @(negedge clk);
    tests++;
    if (qa1.size() != 0 || done1 !== 1'b0 || rdy1 !== 1'b1) begin
      fails++; $display("FAIL abort_partial got n%0d d%0b r%0b want n0 d0 r1",
                        qa1.size(), done1, rdy1);
    end
    send(8'h44, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1);
`endif
    settle();
    tests++;
    if (qa1.size() != 1) begin
      fails++; $display("FAIL abort_count got %0d want 1", qa1.size());
    end
    tests++;
    if (qa1.size() < 1 || qa1[0] !== 64'd16 || qd1[0] !== 32'h44332211) begin
      fails++; $display("FAIL abort_word got %h/%h want 10/44332211", qa1[0], qd1[0]);
    end
    tests++;
    if (qa0.size() != 1 || qa0[0] !== 64'd0 || qd0[0] !== 32'h44332211) begin
      fails++; $display("FAIL abort_base0 got n%0d %h/%h want 1 0/44332211",
                        qa0.size(), qa0[0], qd0[0]);
    end
    tests++;
    if (done1 !== 1'b1 || cr1 !== 1'b0) begin
      fails++; $display("FAIL abort_done got d%0b c%0b want d1 c0", done1, cr1);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h00, 0);
    settle();
    tests++;
    if (qa0.size() != 1 || qd0[0] !== 32'h44332211) begin
      fails++; $display("FAIL csum_write got n%0d %h want 1 44332211", qa0.size(), qd0[0]);
    end
    tests++;
    if (err0 !== 1'b1 || done0 !== 1'b0) begin
      fails++; $display("FAIL csum_err got e%0b d%0b want e1 d0", err0, done0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load2();
    test_zero_len();
    test_overflow();
    test_max_boundary();
    test_abort_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
